// File: rtl/wb_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: address/data widths
// and the MDU result FIFO entry.
package wb_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] a3;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     pc;
  } md_entry_t;

endpackage

// File: rtl/wb_write_arbiter_md_fifo.sv
// MDU result FIFO with per-entry squash-by-address; exposes the head,
// occupancy flags and the live/address view used for the pending mask.
module md_result_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push,
  input  md_entry_t                            push_entry,
  input  logic                                 pop,
  input  logic                                 squash,
  input  logic [REG_ADDR_W-1:0]                squash_a3,
  output md_entry_t                            head,
  output logic                                 empty,
  output logic                                 full,
  output logic [DEPTH-1:0]                     live_vec,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     a3_vec
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] wr_ptr_r;
  logic [PTR_W:0] rd_ptr_r;
  md_entry_t      mem_r [DEPTH];

  // Storage and pointers; popped slots drop live so the mask only sees queued entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && (mem_r[i].a3 == squash_a3)) begin
          mem_r[i].live <= 1'b0;
        end
      end
      if (pop) begin
        mem_r[rd_ptr_r[PTR_W-1:0]].live <= 1'b0;
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      // Written last so a same-cycle squash never kills the younger incoming entry.
      if (push) begin
        mem_r[wr_ptr_r[PTR_W-1:0]] <= push_entry;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  assign head  = mem_r[rd_ptr_r[PTR_W-1:0]];
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                 (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

  // Flatten entry state for the pending-mask reduction.
  always_comb begin
    live_vec = '0;
    a3_vec   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_vec[i] = mem_r[i].live;
      a3_vec[i]   = mem_r[i].a3;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: WB always wins, queued MDU results
// drain into idle WB cycles, and a pending mask feeds the hazard unit.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int MD_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_a3,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic [DATA_W-1:0]     wb_pc,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_a3,
  input  logic [DATA_W-1:0]     md_data,
  input  logic [DATA_W-1:0]     md_pc,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [DATA_W-1:0]     RegData,
  output logic                  RegWrite,
  output logic [DATA_W-1:0]     Current_PC,
  output logic [CNT_W-1:0]      times_W,
  output logic [31:0]           pending
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  md_entry_t                             head_s;
  md_entry_t                             push_entry_s;
  logic                                  empty_s;
  logic                                  full_s;
  logic                                  push_s;
  logic                                  pop_s;
  logic                                  squash_s;
  logic [MD_DEPTH-1:0]                   live_vec_s;
  logic [MD_DEPTH-1:0][REG_ADDR_W-1:0]   a3_vec_s;
  logic [31:0]                           pending_s;
  logic [CNT_W-1:0]                      cnt_r;

  assign md_ready     = ~full_s;
  assign push_s       = md_valid & ~full_s;
  assign pop_s        = ~wb_valid & ~empty_s;
  assign squash_s     = wb_valid & (wb_a3 != 5'd0);
  assign push_entry_s = '{live: 1'b1, a3: md_a3, data: md_data, pc: md_pc};

  md_result_fifo #(.DEPTH(MD_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .squash     (squash_s),
    .squash_a3  (wb_a3),
    .head       (head_s),
    .empty      (empty_s),
    .full       (full_s),
    .live_vec   (live_vec_s),
    .a3_vec     (a3_vec_s)
  );

  // Commit-cycle counter and registered RF write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r      <= '0;
      A3         <= '0;
      RegData    <= '0;
      RegWrite   <= 1'b0;
      Current_PC <= '0;
      times_W    <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
      if (wb_valid) begin
        A3         <= wb_a3;
        RegData    <= wb_data;
        Current_PC <= wb_pc;
        RegWrite   <= 1'b1;
        times_W    <= cnt_r;
      end else if (!empty_s) begin
        A3         <= head_s.a3;
        RegData    <= head_s.data;
        Current_PC <= head_s.pc;
        RegWrite   <= head_s.live;
        if (head_s.live) begin
          times_W <= cnt_r;
        end
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  // Pending mask from queued live entries; r0 writes are harmless so bit 0 stays clear.
  always_comb begin
    pending_s = '0;
    for (int i = 0; i < MD_DEPTH; i++) begin
      pending_s[a3_vec_s[i]] = pending_s[a3_vec_s[i]] | live_vec_s[i];
    end
    pending_s[0] = 1'b0;
  end

  assign pending = pending_s;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized scoreboard bench for wb_write_arbiter against a queue-based
// reference model of the write-port arbitration rules.
module tb_wb_write_arbiter;

  localparam int MD_DEPTH = 4;
  localparam int CNT_W    = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, md_valid, md_ready, RegWrite;
  logic [4:0]  wb_a3, md_a3, A3;
  logic [31:0] wb_data, wb_pc, md_data, md_pc, RegData, Current_PC, times_W, pending;

  always #5 clk = ~clk;

  wb_write_arbiter #(.MD_DEPTH(MD_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_a3(wb_a3), .wb_data(wb_data), .wb_pc(wb_pc),
    .md_valid(md_valid), .md_ready(md_ready), .md_a3(md_a3), .md_data(md_data), .md_pc(md_pc),
    .A3(A3), .RegData(RegData), .RegWrite(RegWrite), .Current_PC(Current_PC),
    .times_W(times_W), .pending(pending)
  );

  typedef struct {logic live; logic [4:0] a3; logic [31:0] data; logic [31:0] pc;} ment_t;
  typedef struct {logic [4:0] a3; logic [31:0] data; logic [31:0] pc; logic [31:0] t;} wr_t;

  ment_t       mq[$];
  wr_t         exp_q[$];
  logic [31:0] cnt_m;
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = 32'd0;
    foreach (mq[i]) if (mq[i].live && mq[i].a3 != 5'd0) p[mq[i].a3] = 1'b1;
    return p;
  endfunction

  // One clock of stimulus; the model predicts the writes of the coming edge.
  task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] wp,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md, input logic [31:0] mp);
    bit    accept;
    ment_t e;
    @(negedge clk);
    reset = 1'b1;
    wb_valid = wv; wb_a3 = wa; wb_data = wd; wb_pc = wp;
    md_valid = mv; md_a3 = ma; md_data = md; md_pc = mp;
    #1;
    chk("md_ready", md_ready, (mq.size() < MD_DEPTH));
    chk("pending", pending, model_pending());
    accept = mv && (mq.size() < MD_DEPTH);
    if (wv) begin
      exp_q.push_back('{wa, wd, wp, cnt_m});
      if (wa != 5'd0) foreach (mq[i]) if (mq[i].a3 == wa) mq[i].live = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live) exp_q.push_back('{e.a3, e.data, e.pc, cnt_m});
    end
    if (accept) mq.push_back('{1'b1, ma, md, mp});
    cnt_m = cnt_m + 32'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // Holds reset low for n edges; the next step releases it.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0; wb_valid = 1'b0; md_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
    mq.delete();
    cnt_m = 32'd0;
  endtask

  // Monitor: every RF write must match the oldest predicted write.
  always @(posedge clk) begin
    wr_t w;
    #1;
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got a3=%0d data=%0h expected no write", A3, RegData);
      end else begin
        w = exp_q.pop_front();
        chk("A3", A3, w.a3);
        chk("RegData", RegData, w.data);
        chk("Current_PC", Current_PC, w.pc);
        chk("times_W", times_W, w.t);
      end
    end
  end

  initial begin
    reset = 1'b0; wb_valid = 1'b0; md_valid = 1'b0;
    wb_a3 = 5'd0; wb_data = 32'd0; wb_pc = 32'd0;
    md_a3 = 5'd0; md_data = 32'd0; md_pc = 32'd0;
    cnt_m = 32'd0;

    // 1: reset state
    do_reset(3);
    #1;
    chk("rst_A3", A3, 5'd0);
    chk("rst_RegData", RegData, 32'd0);
    chk("rst_RegWrite", RegWrite, 1'b0);
    chk("rst_Current_PC", Current_PC, 32'd0);
    chk("rst_times_W", times_W, 32'd0);
    chk("rst_pending", pending, 32'd0);

    // 2: lone WB write, first cycle after reset so times_W = 0
    step(1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'd0, 32'd0);
    @(posedge clk); #2;
    chk("t2_RegWrite", RegWrite, 1'b1);
    chk("t2_A3", A3, 5'd5);
    chk("t2_RegData", RegData, 32'h1234);
    chk("t2_pc", Current_PC, 32'h3000);
    chk("t2_times", times_W, 32'd0);

    // 3: MDU r8 waits behind three WB cycles
    step(1'b1, 5'd1, 32'h11, 32'h4000, 1'b1, 5'd8, 32'hAA, 32'h5000);
    step(1'b1, 5'd2, 32'h22, 32'h4004, 1'b0, 5'd0, 32'd0, 32'd0);
    chk("t3_pending8", pending[8], 1'b1);
    step(1'b1, 5'd3, 32'h33, 32'h4008, 1'b0, 5'd0, 32'd0, 32'd0);
    idle(2);
    chk("t3_pending_clear", pending, 32'd0);

    // 4: queued r9 squashed by a younger WB write to r9
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd9, 32'hDEAD, 32'h6000);
    step(1'b1, 5'd9, 32'h55, 32'h6004, 1'b0, 5'd0, 32'd0, 32'd0);
    idle(1);
    @(posedge clk); #2;
    chk("t4_dead_pop", RegWrite, 1'b0);
    idle(1);

    // 5: fill the FIFO under continuous WB, then drain in order
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'(10 + i), 32'h100 + i, 32'h7000 + 4 * i, 1'b1, 5'(20 + i), 32'h200 + i, 32'h8000 + 4 * i);
    chk("t5_full", md_ready, 1'b0);
    idle(6);

    // 6: reset with two entries queued
    step(1'b1, 5'd1, 32'h1, 32'h9000, 1'b1, 5'd12, 32'hC0, 32'h9100);
    step(1'b1, 5'd2, 32'h2, 32'h9004, 1'b1, 5'd13, 32'hC1, 32'h9104);
    do_reset(2);
    idle(4);
    chk("t6_pending", pending, 32'd0);

    // Random traffic with narrow address range for collisions
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom, $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 15)), $urandom, $urandom);
    end
    idle(MD_DEPTH + 2);
    @(posedge clk); #2;
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
